// File: rtl/ghost_wall_arbiter.sv
// ghost_wall_arbiter
// Shares the single-port maze wall ROM among all ghost movers. A frame tick
// snapshots every ghost, then one probe per cycle walks the slots
// (ghost-major, direction order up/down/left/right). Results build up in a
// shadow register and are published to the four wall vectors all at once,
// so the movers never see a half-finished sweep.
module ghost_wall_arbiter #(
    parameter int N_GHOSTS = 4,
    parameter int X_LIMIT  = 639,
    parameter int Y_LIMIT  = 479
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [10*N_GHOSTS-1:0]  GhostX_all,
    input  logic [10*N_GHOSTS-1:0]  GhostY_all,
    input  logic [10*N_GHOSTS-1:0]  GhostS_all,
    output logic                    maze_rd,
    output logic [10:0]             maze_addr,
    input  logic                    maze_data,
    output logic [N_GHOSTS-1:0]     UpWall,
    output logic [N_GHOSTS-1:0]     DownWall,
    output logic [N_GHOSTS-1:0]     LeftWall,
    output logic [N_GHOSTS-1:0]     RightWall,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int NSLOT  = 4 * N_GHOSTS;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [10*N_GHOSTS-1:0] snap_x_q, snap_x_d;
    logic [10*N_GHOSTS-1:0] snap_y_q, snap_y_d;
    logic [10*N_GHOSTS-1:0] snap_s_q, snap_s_d;
    logic                   maze_rd_q, maze_rd_d;
    logic [10:0]            maze_addr_q, maze_addr_d;
    logic                   oob_q, oob_d;
    logic                   cap_valid_q, cap_valid_d;
    logic [SLOT_W-1:0]      cap_slot_q, cap_slot_d;
    logic                   cap_oob_q, cap_oob_d;
    logic [NSLOT-1:0]       shadow_q, shadow_d;
    logic [N_GHOSTS-1:0]    up_q, up_d, down_q, down_d;
    logic [N_GHOSTS-1:0]    left_q, left_d, right_q, right_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    // Intermediate combinational values for the slot being issued.
    logic [SLOT_W-1:0]      issue_slot_s;
    logic                   issue_now_s;
    logic [9:0]             sel_x_s, sel_y_s, sel_s_s;
    logic [11:0]            probe_s;
    logic [NSLOT-1:0]       shadow_next_s;
    int                     gidx_s;

    // Probe one pixel past the chosen edge. Returns {oob, addr}. Any borrow
    // wraps the 11-bit coordinate to >= 1024, so the limit compare also
    // catches probes that went off the top or left of the screen.
    function automatic logic [11:0] probe_tile(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] s,
        input logic [1:0] dir
    );
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] reach;
        logic        oob;
        reach = {1'b0, s} + 11'd1;
        px    = {1'b0, x};
        py    = {1'b0, y};
        case (dir)
            2'd0:    py = py - reach;
            2'd1:    py = py + reach;
            2'd2:    px = px - reach;
            2'd3:    px = px + reach;
            default: px = px;
        endcase
        oob = (px > 11'(X_LIMIT)) || (py > 11'(Y_LIMIT));
        return oob ? {1'b1, 11'd0} : {1'b0, py[8:4], px[9:4]};
    endfunction

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one sweep per accepted start, then a single drain cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_SWEEP : ST_IDLE;
            ST_SWEEP: state_d = (slot_q == LAST_SLOT) ? ST_DRAIN : ST_SWEEP;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath/outputs: probe issue, result capture, commit and status flags.
    always_comb begin
        // In IDLE the first slot is issued straight from the live inputs,
        // which are exactly what the snapshot captures on the same edge.
        issue_now_s  = ((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_SWEEP) && (slot_q != LAST_SLOT));
        issue_slot_s = (state_q == ST_IDLE) ? '0 : (slot_q + SLOT_ONE);
        gidx_s       = int'(issue_slot_s[SLOT_W-1:2]);

        sel_x_s = 10'd0;
        sel_y_s = 10'd0;
        sel_s_s = 10'd0;
        for (int g = 0; g < N_GHOSTS; g++) begin
            if (gidx_s == g) begin
                sel_x_s = (state_q == ST_IDLE) ? GhostX_all[10*g +: 10] : snap_x_q[10*g +: 10];
                sel_y_s = (state_q == ST_IDLE) ? GhostY_all[10*g +: 10] : snap_y_q[10*g +: 10];
                sel_s_s = (state_q == ST_IDLE) ? GhostS_all[10*g +: 10] : snap_s_q[10*g +: 10];
            end else begin
                sel_x_s = sel_x_s;
                sel_y_s = sel_y_s;
                sel_s_s = sel_s_s;
            end
        end
        probe_s = probe_tile(sel_x_s, sel_y_s, sel_s_s, issue_slot_s[1:0]);

        if (issue_now_s) begin
            maze_rd_d   = ~probe_s[11];
            maze_addr_d = probe_s[10:0];
            oob_d       = probe_s[11];
        end else begin
            maze_rd_d   = 1'b0;
            maze_addr_d = 11'd0;
            oob_d       = 1'b0;
        end

        if ((state_q == ST_IDLE) && start) begin
            slot_d   = '0;
            snap_x_d = GhostX_all;
            snap_y_d = GhostY_all;
            snap_s_d = GhostS_all;
        end else begin
            slot_d   = issue_now_s ? (slot_q + SLOT_ONE) : slot_q;
            snap_x_d = snap_x_q;
            snap_y_d = snap_y_q;
            snap_s_d = snap_s_q;
        end

        // The slot on the bus this cycle returns data one cycle later.
        cap_valid_d = (state_q == ST_SWEEP);
        cap_slot_d  = slot_q;
        cap_oob_d   = oob_q;

        shadow_next_s = shadow_q;
        if (cap_valid_q) begin
            shadow_next_s[cap_slot_q] = cap_oob_q | maze_data;
        end else begin
            shadow_next_s = shadow_q;
        end
        shadow_d = ((state_q == ST_IDLE) && start) ? '0 : shadow_next_s;

        // Commit uses the merged value so the final slot lands with the rest.
        up_d    = up_q;
        down_d  = down_q;
        left_d  = left_q;
        right_d = right_q;
        if (state_q == ST_DRAIN) begin
            for (int g = 0; g < N_GHOSTS; g++) begin
                up_d[g]    = shadow_next_s[4*g + 0];
                down_d[g]  = shadow_next_s[4*g + 1];
                left_d[g]  = shadow_next_s[4*g + 2];
                right_d[g] = shadow_next_s[4*g + 3];
            end
        end else begin
            up_d    = up_q;
            down_d  = down_q;
            left_d  = left_q;
            right_d = right_q;
        end

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DRAIN);
        overrun_d = overrun_q | (start & (state_q != ST_IDLE));
    end

    // Datapath registers; reset discards any sweep in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q      <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_s_q    <= '0;
            maze_rd_q   <= 1'b0;
            maze_addr_q <= 11'd0;
            oob_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_slot_q  <= '0;
            cap_oob_q   <= 1'b0;
            shadow_q    <= '0;
            up_q        <= '0;
            down_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_s_q    <= snap_s_d;
            maze_rd_q   <= maze_rd_d;
            maze_addr_q <= maze_addr_d;
            oob_q       <= oob_d;
            cap_valid_q <= cap_valid_d;
            cap_slot_q  <= cap_slot_d;
            cap_oob_q   <= cap_oob_d;
            shadow_q    <= shadow_d;
            up_q        <= up_d;
            down_q      <= down_d;
            left_q      <= left_d;
            right_q     <= right_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign maze_rd   = maze_rd_q;
    assign maze_addr = maze_addr_q;
    assign UpWall    = up_q;
    assign DownWall  = down_q;
    assign LeftWall  = left_q;
    assign RightWall = right_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ghost_wall_arbiter.sv
// Self-checking bench for ghost_wall_arbiter: a registered ROM model plus a
// reference that computes every probe tile with plain integer arithmetic.
module tb_ghost_wall_arbiter;

    localparam int NG = 4;
    localparam int XL = 639;
    localparam int YL = 479;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [39:0]   GhostX_all = 40'd0;
    logic [39:0]   GhostY_all = 40'd0;
    logic [39:0]   GhostS_all = 40'd0;
    logic          maze_rd;
    logic [10:0]   maze_addr;
    logic          maze_data = 1'b0;
    logic [NG-1:0] UpWall, DownWall, LeftWall, RightWall;
    logic          busy, done, overrun;
    logic [15:0]   walls_obs;

    int n_checks = 0;
    int n_errs   = 0;

    bit rom [0:2047];
    int gx [NG];
    int gy [NG];
    int gs [NG];
    int sx [NG];
    int sy [NG];
    int ss [NG];
    logic [15:0] committed_w = 16'd0;
    bit          exp_ovr = 1'b0;

    ghost_wall_arbiter #(.N_GHOSTS(NG), .X_LIMIT(XL), .Y_LIMIT(YL)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .GhostX_all(GhostX_all), .GhostY_all(GhostY_all), .GhostS_all(GhostS_all),
        .maze_rd(maze_rd), .maze_addr(maze_addr), .maze_data(maze_data),
        .UpWall(UpWall), .DownWall(DownWall), .LeftWall(LeftWall), .RightWall(RightWall),
        .busy(busy), .done(done), .overrun(overrun)
    );

    assign walls_obs = {UpWall, DownWall, LeftWall, RightWall};

    // System clock.
    always #5 Clk = ~Clk;

    // Registered wall ROM: data appears the cycle after the read strobe.
    always @(posedge Clk) maze_data <= maze_rd ? rom[maze_addr] : 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ghosts();
        for (int g = 0; g < NG; g++) begin
            GhostX_all[10*g +: 10] = 10'(gx[g]);
            GhostY_all[10*g +: 10] = 10'(gy[g]);
            GhostS_all[10*g +: 10] = 10'(gs[g]);
        end
    endtask

    // Probe pixel for ghost g, direction d (0 up, 1 down, 2 left, 3 right).
    function automatic void ref_probe(input int g, input int d, output bit oob, output int addr);
        int px, py;
        px = sx[g];
        py = sy[g];
        case (d)
            0:       py = sy[g] - ss[g] - 1;
            1:       py = sy[g] + ss[g] + 1;
            2:       px = sx[g] - ss[g] - 1;
            default: px = sx[g] + ss[g] + 1;
        endcase
        oob  = (px < 0) || (py < 0) || (px > XL) || (py > YL);
        addr = oob ? 0 : (py / 16) * 64 + (px / 16);
    endfunction

    function automatic logic [15:0] ref_walls();
        logic [3:0] v [4];
        bit oob;
        int addr;
        for (int d = 0; d < 4; d++) begin
            for (int g = 0; g < NG; g++) begin
                ref_probe(g, d, oob, addr);
                v[d][g] = oob ? 1'b1 : rom[addr];
            end
        end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 1'b0;
    endtask

    task automatic random_rom();
        for (int i = 0; i < 2048; i++) rom[i] = ($urandom_range(0, 3) == 0);
    endtask

    // One full sweep from the current negedge. inj: 0 none, 1 extra start
    // sampled at T5, 2 ghost0 X changed to 400 sampled at T3.
    task automatic run_sweep(input int inj);
        logic [15:0] exp_w;
        bit oob;
        int addr;
        sx = gx; sy = gy; ss = gs;
        exp_w = ref_walls();
        start = 1'b1;
        @(negedge Clk);
        for (int c = 1; c <= 18; c++) begin
            start = (inj == 1 && c == 5);
            if (inj == 1 && c == 5) exp_ovr = 1'b1;
            if (inj == 2 && c == 3) begin
                gx[0] = 400;
                drive_ghosts();
            end
            if (c <= 16) begin
                ref_probe((c - 1) / 4, (c - 1) % 4, oob, addr);
                check_eq("slot_rd", 32'(maze_rd), 32'(!oob));
                check_eq("slot_addr", 32'(maze_addr), 32'(addr));
            end
            check_eq("busy", 32'(busy), 32'(c <= 17));
            check_eq("done", 32'(done), 32'(c == 18));
            if (c <= 17) check_eq("walls_hold", 32'(walls_obs), 32'(committed_w));
            if (c < 18) @(negedge Clk);
        end
        check_eq("walls_commit", 32'(walls_obs), 32'(exp_w));
        check_eq("overrun", 32'(overrun), 32'(exp_ovr));
        committed_w = exp_w;
    endtask

    initial begin
        for (int g = 0; g < NG; g++) begin
            gx[g] = 0; gy[g] = 0; gs[g] = 0;
        end
        drive_ghosts();
        clear_rom();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Idle after reset.
        repeat (20) @(negedge Clk);
        check_eq("rst_walls", 32'(walls_obs), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_rd", 32'(maze_rd), 32'd0);
        check_eq("rst_addr", 32'(maze_addr), 32'd0);

        // Single wall tile at row 15, col 14 under ghost0's up probe.
        rom[15 * 64 + 14] = 1'b1;
        gx = '{231, 300, 400, 500};
        gy = '{250, 200, 300, 100};
        gs = '{9, 8, 7, 6};
        drive_ghosts();
        run_sweep(0);
        check_eq("tile_up0", 32'(UpWall[0]), 32'd1);
        check_eq("tile_other0", 32'({DownWall[0], LeftWall[0], RightWall[0]}), 32'd0);

        // Ghost1 probing above the screen is forced to a wall.
        random_rom();
        gx[1] = 100; gy[1] = 5; gs[1] = 9;
        drive_ghosts();
        run_sweep(0);
        check_eq("oob_up1", 32'(UpWall[1]), 32'd1);

        // Second start mid-sweep is ignored but flagged.
        run_sweep(1);

        // Ghost input change after the snapshot has no effect.
        clear_rom();
        rom[15 * 64 + 14] = 1'b1;
        gx[0] = 231; gy[0] = 250; gs[0] = 9;
        drive_ghosts();
        run_sweep(2);
        check_eq("snap_up0", 32'(UpWall[0]), 32'd1);

        // Random sweeps, some back-to-back at the minimum period.
        for (int r = 0; r < 20; r++) begin
            random_rom();
            for (int g = 0; g < NG; g++) begin
                gx[g] = $urandom_range(0, 660);
                gy[g] = $urandom_range(0, 500);
                gs[g] = $urandom_range(0, 40);
            end
            drive_ghosts();
            run_sweep(0);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        // Reset in the middle of a sweep that would commit walls.
        for (int i = 0; i < 2048; i++) rom[i] = 1'b1;
        gx = '{100, 200, 300, 400};
        gy = '{100, 150, 200, 250};
        gs = '{8, 8, 8, 8};
        drive_ghosts();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_walls", 32'(walls_obs), 32'd0);
        check_eq("mid_rst_rd", 32'(maze_rd), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        committed_w = 16'd0;
        exp_ovr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            check_eq("post_rst_walls", 32'(walls_obs), 32'd0);
            check_eq("post_rst_done", 32'(done), 32'd0);
        end
        run_sweep(0);
        check_eq("all_walls", 32'(walls_obs), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
